// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl_pkg
//  Description : Shared constants for the data-memory responder: bus widths,
//                funct3 access codes, FSM state encodings, default depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

  localparam int MEM_ADDR_W              = 32;
  localparam int WORD_W                  = 32;
  localparam int FUNCT3_W                = 3;
  localparam int DMEM_DEPTH_LOG2_DEFAULT = 12;

  localparam logic [FUNCT3_W-1:0] INST_BYTE        = 3'b000;
  localparam logic [FUNCT3_W-1:0] INST_HALF_WORD   = 3'b001;
  localparam logic [FUNCT3_W-1:0] INST_WORD        = 3'b010;
  localparam logic [FUNCT3_W-1:0] INST_BYTE_U      = 3'b100;
  localparam logic [FUNCT3_W-1:0] INST_HALF_WORD_U = 3'b101;

  typedef enum logic [1:0] {
    DMEM_IDLE    = 2'd0,
    DMEM_RD_WAIT = 2'd1,
    DMEM_RD_DONE = 2'd2
  } dmem_state_e;

  // True when the access size cannot be served from the given lane offset.
  function automatic logic is_misaligned(input logic [FUNCT3_W-1:0] f3,
                                         input logic [1:0]          off);
    logic r;
    r = 1'b0;
    case (f3)
      INST_HALF_WORD, INST_HALF_WORD_U: r = off[0];
      INST_WORD:                        r = (off != 2'b00);
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sram
//  Description : Single-port synchronous RAM, 32-bit words, per-byte write
//                enables, registered read data (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Byte-lane writes; unselected lanes keep their contents.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read port: data appears the cycle after the request.
  always_ff @(posedge clk) begin
    if (en && !we) rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : Data-memory responder for the core load/store port. Stores
//                complete in one cycle with byte enables; loads take three
//                cycles and return the word shifted so the addressed lane
//                sits at bit 0 (no extension).
//  Options     : DMEM_MISALIGN_CHECK_EN - reject misaligned half/word
//                accesses and raise a one-cycle misalign_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wmem_en_i,
  input  logic                  rmem_en_i,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [WORD_W-1:0]     wmem_data_i,
  input  logic [FUNCT3_W-1:0]   funct3_i,
  output logic [WORD_W-1:0]     rmem_data_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  dmem_state_e           state, state_nxt;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            off, off_q;
  logic                  misalign_now;
  logic                  store_go, load_go;
  logic [3:0]            be;
  logic [WORD_W-1:0]     wdata, rdata;
  logic                  unused_addr_bits;

  // Upper address bits are ignored so accesses wrap modulo the capacity.
  assign word_idx         = mem_addr_i[DEPTH_LOG2+1:2];
  assign off              = mem_addr_i[1:0];
  assign unused_addr_bits = ^mem_addr_i[MEM_ADDR_W-1:DEPTH_LOG2+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_now = is_misaligned(funct3_i, off);
`else
  assign misalign_now = 1'b0;
`endif

  // A store wins over a simultaneous load.
  assign store_go = (state == DMEM_IDLE) && wmem_en_i && !misalign_now;
  assign load_go  = (state == DMEM_IDLE) && rmem_en_i && !wmem_en_i && !misalign_now;

  // Store lane steering: replicate the payload across lanes, pick lanes by be.
  always_comb begin
    be    = 4'b0000;
    wdata = wmem_data_i;
    case (funct3_i)
      INST_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{wmem_data_i[7:0]}};
      end
      INST_HALF_WORD: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{wmem_data_i[15:0]}};
      end
      INST_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    if (!store_go) be = 4'b0000;
  end

  dmem_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .en   (store_go || load_go),
    .we   (store_go),
    .be   (be),
    .addr (word_idx),
    .wdata(wdata),
    .rdata(rdata)
  );

  // Next state and stall: stall is combinational only while accepting a load.
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      DMEM_IDLE: begin
        if (load_go) begin
          state_nxt = DMEM_RD_WAIT;
          stall_o   = !rst;
        end
      end
      DMEM_RD_WAIT: begin
        stall_o   = 1'b1;
        state_nxt = DMEM_RD_DONE;
      end
      DMEM_RD_DONE: state_nxt = DMEM_IDLE;
      default:      state_nxt = DMEM_IDLE;
    endcase
  end

  // State, latched lane offset and the lane-aligned load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DMEM_IDLE;
      off_q       <= 2'b00;
      rmem_data_o <= '0;
    end else begin
      state <= state_nxt;
      if (load_go) off_q <= off;
      if (state == DMEM_RD_WAIT) rmem_data_o <= rdata >> {off_q, 3'b000};
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  // One-cycle pulse for any rejected misaligned request seen in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_o <= 1'b0;
    else     misalign_o <= (state == DMEM_IDLE) && (wmem_en_i || rmem_en_i) && misalign_now;
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_ctrl
//  Description : Self-checking bench for dmem_ctrl; load results are checked
//                against a queue of expected values filled at request time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int DL2 = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        wmem_en, rmem_en;
  logic [31:0] addr, wdata;
  logic [2:0]  f3;
  logic [31:0] rdata;
  logic        stall, misalign;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[8];
  logic        prev_stall = 1'b0;

  dmem_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wmem_en_i  (wmem_en),
    .rmem_en_i  (rmem_en),
    .mem_addr_i (addr),
    .wmem_data_i(wdata),
    .funct3_i   (f3),
    .rmem_data_o(rdata),
    .stall_o    (stall),
    .misalign_o (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load completion monitor: stall falling outside reset marks valid data.
  always @(posedge clk) begin
    #1;
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && !stall) begin
        if (exp_q.size() == 0) check_val("load_unexpected", 32'(exp_q.size()), 32'd1);
        else check_val("load_data", rdata, exp_q.pop_front());
      end
      prev_stall = stall;
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    wmem_en = 1'b1; rmem_en = 1'b0; addr = a; wdata = d; f3 = f;
    #1 check_val("store_stall", 32'(stall), 32'd0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp);
    @(negedge clk);
    wmem_en = 1'b0; rmem_en = 1'b1; addr = a; f3 = f;
    #1 check_val("load_stall_req", 32'(stall), 32'd1);
    exp_q.push_back(exp);
    @(negedge clk);
    check_val("load_stall_wait", 32'(stall), 32'd1);
    @(negedge clk);
    check_val("load_stall_done", 32'(stall), 32'd0);
    rmem_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wmem_en = 1'b0; rmem_en = 1'b0; addr = '0; wdata = '0; f3 = INST_WORD;
    repeat (3) @(negedge clk);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_misalign", 32'(misalign), 32'd0);
    rst = 1'b0;

    // Word store / load round trip, then byte and halfword merges.
    do_store(32'h10, 32'hDEADBEEF, INST_WORD);
    do_load (32'h10, INST_WORD, 32'hDEADBEEF);
    do_store(32'h12, 32'h0000005A, INST_BYTE);
    do_load (32'h10, INST_WORD, 32'hDE5ABEEF);
    do_load (32'h12, INST_BYTE_U, 32'h0000DE5A);
    do_store(32'h14, 32'h89ABCDEF, INST_WORD);
    do_store(32'h16, 32'h00001234, INST_HALF_WORD);
    do_load (32'h14, INST_WORD, 32'h1234CDEF);
    do_load (32'h16, INST_HALF_WORD, 32'h00001234);

    // Address wrap beyond capacity aliases word 2.
    do_store((32'd4 << DL2) + 32'd8, 32'h0BADF00D, INST_WORD);
    do_load (32'h8, INST_WORD, 32'h0BADF00D);

`ifdef DMEM_MISALIGN_CHECK_EN
    @(negedge clk);
    wmem_en = 1'b0; rmem_en = 1'b1; addr = 32'h11; f3 = INST_WORD;
    #1 check_val("misalign_no_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rmem_en = 1'b0;
    check_val("misalign_pulse", 32'(misalign), 32'd1);
    check_val("misalign_rdata_held", rdata, 32'h0BADF00D);
    @(negedge clk);
    check_val("misalign_pulse_end", 32'(misalign), 32'd0);
    do_load(32'h10, INST_WORD, 32'hDE5ABEEF);
`else
    do_store(32'h11, 32'hAABBCCDD, INST_WORD);
    @(negedge clk);
    wmem_en = 1'b0;
    check_val("misalign_tied", 32'(misalign), 32'd0);
    do_load(32'h10, INST_WORD, 32'hAABBCCDD);
    do_load(32'h11, INST_WORD, 32'h00AABBCC);
`endif

    // Reset in the middle of a load discards it.
    @(negedge clk);
    wmem_en = 1'b0; rmem_en = 1'b1; addr = 32'h10; f3 = INST_WORD;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midload_rst_stall", 32'(stall), 32'd0);
    check_val("midload_rst_rdata", rdata, 32'd0);
    rmem_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_val("midload_rst_rdata_hold", rdata, 32'd0);
    do_load(32'h14, INST_WORD, 32'h1234CDEF);

    // Random aligned traffic against a small word model at 0x40..0x5C.
    for (int k = 0; k < 8; k++) begin
      model[k] = $urandom;
      do_store(32'h40 + 32'(4*k), model[k], INST_WORD);
    end
    for (int n = 0; n < 24; n++) begin
      int          k, op;
      logic [1:0]  o;
      logic [31:0] d;
      k = $urandom_range(0, 7);
      op = $urandom_range(0, 5);
      o = 2'($urandom_range(0, 3));
      d = $urandom;
      case (op)
        0: begin
          do_store(32'h40 + 32'(4*k) + 32'(o), {24'd0, d[7:0]}, INST_BYTE);
          model[k][8*o +: 8] = d[7:0];
        end
        1: begin
          o[0] = 1'b0;
          do_store(32'h40 + 32'(4*k) + 32'(o), {16'd0, d[15:0]}, INST_HALF_WORD);
          model[k][8*o +: 16] = d[15:0];
        end
        2: begin
          do_store(32'h40 + 32'(4*k), d, INST_WORD);
          model[k] = d;
        end
        3: do_load(32'h40 + 32'(4*k), INST_WORD, model[k]);
        4: do_load(32'h40 + 32'(4*k) + 32'(o), INST_BYTE_U, model[k] >> (8*o));
        default: begin
          o[0] = 1'b0;
          do_load(32'h40 + 32'(4*k) + 32'(o), INST_HALF_WORD_U, model[k] >> (8*o));
        end
      endcase
    end

    @(negedge clk);
    wmem_en = 1'b0; rmem_en = 1'b0;
    repeat (4) @(negedge clk);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder on the memory side of the core's load/store interface. It accepts the load/store request produced by the mem pipeline stage and performs the access against an on-chip single-port synchronous SRAM. Stores use byte enables. Load data is shifted so the addressed byte or halfword lands at bit 0, and the mem stage applies sign or zero extension.

## Interface
Parameters:
- DEPTH_LOG2, 12, SRAM depth in 32-bit words (log2); byte capacity is 4·2^DEPTH_LOG2.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wmem_en_i  in  1  store request.
- rmem_en_i  in  1  load request.
- mem_addr_i  in  `MemAddrBus  byte address.
- wmem_data_i  in  `WordBus  store data, zero-extended, payload in the low bits.
- funct3_i  in  `Funct3Bus  access size/sign code (`INST_BYTE`, `INST_HALF_WORD`, `INST_WORD`, `INST_BYTE_U`, `INST_HALF_WORD_U`).
- rmem_data_o  out  `WordBus  lane-aligned load data; raw, not extended.
- stall_o  out  1  the requester must hold the pipeline and keep its inputs stable.
- misalign_o  out  1  one-cycle misaligned-access flag; tied 0 unless the macro is enabled.

## Operation
- FSM states: IDLE, RD_WAIT, RD_DONE.
- Word index is mem_addr_i[DEPTH_LOG2+1:2]; higher address bits are ignored, so accesses wrap modulo capacity. Lane offset off is mem_addr_i[1:0].
- IDLE, store (wmem_en_i=1):
  - SB: be = 4'b0001<<off, write data = {4{byte}}.
  - SH: be = 4'b0011<<{off[1],1'b0}, write data = {2{half}}.
  - SW: be = 4'b1111.
  - Any other funct3: be = 0, no write.
  - Write completes this cycle; stay in IDLE; stall_o = 0.
- IDLE, load (rmem_en_i=1, wmem_en_i=0): issue the SRAM read, latch off, assert stall_o, go to RD_WAIT.
- Both enables high: the store is performed and the load is ignored.
- RD_WAIT: SRAM data is valid. Register rmem_data_o = rdata >> (8·off), keep stall_o = 1, go to RD_DONE.
- RD_DONE: stall_o = 0 and rmem_data_o holds the load result. Requester inputs are ignored this cycle; go to IDLE.
- rmem_data_o keeps its last value until the next load completes.
- Reset, including mid-load: state goes to IDLE; rmem_data_o, stall_o and misalign_o go to 0. SRAM contents are not cleared. An in-flight load is discarded.

## Timing
- Store: zero-stall, written at the edge that ends cycle N.
- Load requested in cycle N: stall_o = 1 in N and N+1; data is valid with stall_o = 0 in N+2. A back-to-back request is accepted at N+3 at the earliest.
- stall_o is a combinational function of state and request in IDLE, and registered-state-only in RD_WAIT and RD_DONE.
- SRAM read latency is 1 cycle. A read of a word written in the previous cycle returns the new data.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - A halfword access with off[0]=1, or a word access with off≠0, performs no SRAM access and no stall.
  - misalign_o is registered high for exactly the next cycle.
  - rmem_data_o is unchanged.
- Undefined: misalign_o is constant 0.
  - Misaligned halfwords use lanes {off[1],0}.
  - Words ignore off for the write.
  - Loads still shift by off, so upper bytes read 0.

## Structure
- The shared header holds the FSM state encodings (`DMEM_IDLE`, `DMEM_RD_WAIT`, `DMEM_RD_DONE`) and `DMEM_DEPTH_LOG2_DEFAULT`, alongside the existing funct3 and width constants.
- One sub-module, dmem_sram: a single-port, byte-enable, 1-cycle-read synchronous RAM parameterised by DEPTH_LOG2.
- The FSM, lane steering and misalign logic stay in dmem_ctrl.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → stall_o high for 2 cycles, then rmem_data_o = 0xDEADBEEF with stall_o low.
- After the above, SB 0x5A @0x12, then LW @0x10 → 0xDE5ABEEF; LBU @0x12 → 0x0000005A in the low byte after the shift.
- SH 0x1234 @0x16, then LW @0x14 → 0x1234xxxx (upper half written, lower half preserved); LH @0x16 → low half 0x1234.
- Address 4·2^DEPTH_LOG2 + 8 aliases word 2: SW there, then LW @0x8 → same data.
- Assert rst during RD_WAIT → stall_o = 0 and rmem_data_o = 0 immediately; the next LW completes normally.
- With DMEM_MISALIGN_CHECK_EN: LW @0x11 → misalign_o = 1 for one cycle, no stall, memory unchanged. Without the macro: SW 0xAABBCCDD @0x11 lands at word 0x10.
